// File: rtl/eje4_pkg.sv
// Shared definitions for the eje4 equivalence sweep: FSM encodings, vector
// count and mismatch-mask bit positions.
package eje4_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int unsigned N_VEC = 64;

    localparam int unsigned MASK_F = 0;
    localparam int unsigned MASK_G = 1;
    localparam int unsigned MASK_H = 2;

endpackage

// File: rtl/eje4_sweep_ctrl_if.sv
// Bus between the sweep controller and eje4: six vector bits out, the
// outputs of both eje4 implementations back.
interface eje4_sweep_ctrl_if;

    logic A;
    logic B;
    logic C;
    logic D;
    logic E;
    logic F;
    logic f_1;
    logic g_1;
    logic h_1;
    logic f_2;
    logic g_2;
    logic h_2;

    modport master (
        output A, B, C, D, E, F,
        input  f_1, g_1, h_1, f_2, g_2, h_2
    );

    modport slave (
        input  A, B, C, D, E, F,
        output f_1, g_1, h_1, f_2, g_2, h_2
    );

endinterface

// File: rtl/eje4_cmp.sv
// Output-by-output comparison of the two eje4 implementations; X or Z on
// either side counts as a mismatch.
module eje4_cmp
    import eje4_pkg::*;
(
    input  logic       f_1,
    input  logic       g_1,
    input  logic       h_1,
    input  logic       f_2,
    input  logic       g_2,
    input  logic       h_2,
    output logic [2:0] mask
);

    // Case-inequality so unknown outputs are flagged, never hidden.
    always_comb begin
        mask         = 3'b000;
        mask[MASK_F] = (f_1 !== f_2);
        mask[MASK_G] = (g_1 !== g_2);
        mask[MASK_H] = (h_1 !== h_2);
    end

endmodule

// File: rtl/eje4_sweep_ctrl.sv
// Sweeps all 64 eje4 input vectors, waits SETTLE_CYC cycles per vector and
// records how many vectors made the two implementations disagree.
module eje4_sweep_ctrl
    import eje4_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    eje4_sweep_ctrl_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [6:0]            err_count,
    output logic                  first_err_valid,
    output logic [5:0]            first_err_vec,
    output logic [2:0]            first_err_mask
);

    localparam logic [3:0] SETTLE_LAST  = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
    localparam logic [1:0] ST_AFTER_VEC = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;
    localparam logic [5:0] LAST_VEC     = 6'(N_VEC - 1);

    logic [1:0] state_r;
    logic [5:0] vec_r;
    logic [3:0] cnt_r;
    logic [2:0] mask_s;
    logic       mismatch_s;

    eje4_cmp u_cmp (
        .f_1  (bus.f_1),
        .g_1  (bus.g_1),
        .h_1  (bus.h_1),
        .f_2  (bus.f_2),
        .g_2  (bus.g_2),
        .h_2  (bus.h_2),
        .mask (mask_s)
    );

    assign mismatch_s = |mask_s;
    assign {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F} = vec_r;

    // Sweep sequencer and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            vec_r           <= 6'd0;
            cnt_r           <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 7'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 6'd0;
            first_err_mask  <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r         <= ST_AFTER_VEC;
                        vec_r           <= 6'd0;
                        cnt_r           <= 4'd0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 7'd0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= 6'd0;
                        first_err_mask  <= 3'b000;
                    end
                end
                ST_SETTLE: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        err_count <= err_count + 7'd1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec_r;
                            first_err_mask  <= mask_s;
                        end
                    end
                    if (vec_r == LAST_VEC) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // err_count has not yet absorbed this vector's result.
                        pass    <= !mismatch_s && (err_count == 7'd0);
                    end else begin
                        vec_r   <= vec_r + 6'd1;
                        cnt_r   <= 4'd0;
                        state_r <= ST_AFTER_VEC;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eje4_sweep_ctrl.sv
// Directed bench for eje4_sweep_ctrl with a behavioural eje4 stand-in whose
// second implementation can be perturbed per scenario.
module tb_eje4_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start0;
    int         mode;

    logic       busy, done, pass, first_err_valid;
    logic [6:0] err_count;
    logic [5:0] first_err_vec;
    logic [2:0] first_err_mask;

    logic       busy0, done0, pass0, first_err_valid0;
    logic [6:0] err_count0;
    logic [5:0] first_err_vec0;
    logic [2:0] first_err_mask0;

    int n_vec;
    int n_err;

    eje4_sweep_ctrl_if bus ();
    eje4_sweep_ctrl_if bus0 ();

    eje4_sweep_ctrl #(.SETTLE_CYC(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec),
        .first_err_mask  (first_err_mask)
    );

    eje4_sweep_ctrl #(.SETTLE_CYC(0)) dut0 (
        .clk             (clk),
        .reset           (reset),
        .start           (start0),
        .bus             (bus0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .err_count       (err_count0),
        .first_err_valid (first_err_valid0),
        .first_err_vec   (first_err_vec0),
        .first_err_mask  (first_err_mask0)
    );

    // eje4 stand-in; mode 1 flips f_2 at vector 37, mode 2 flips g_2 when E (vec[1]) is set.
    function automatic logic [5:0] eje4_model(input logic [5:0] v, input int m);
        logic a, b, c, d, e, f, f1, g1, h1, f2, g2, h2;
        {a, b, c, d, e, f} = v;
        f1 = (a & b) | (~c & d);
        g1 = e ^ f ^ a;
        h1 = ~(b | f) | c;
        f2 = f1;
        g2 = g1;
        h2 = h1;
        if (m == 1 && v == 6'd37) f2 = ~f1;
        if (m == 2) g2 = g1 ^ e;
        return {h2, g2, f2, h1, g1, f1};
    endfunction

    assign {bus.h_2, bus.g_2, bus.f_2, bus.h_1, bus.g_1, bus.f_1} =
        eje4_model({bus.A, bus.B, bus.C, bus.D, bus.E, bus.F}, mode);
    assign {bus0.h_2, bus0.g_2, bus0.f_2, bus0.h_1, bus0.g_1, bus0.f_1} =
        eje4_model({bus0.A, bus0.B, bus0.C, bus0.D, bus0.E, bus0.F}, mode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_pulse(input bit sel0);
        @(negedge clk);
        if (sel0) start0 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start  = 1'b0;
    endtask

    task automatic wait_done(input bit sel0, output int cycles);
        cycles = -1;
        for (int k = 0; k < 400; k++) begin
            if ((sel0 ? done0 : done) === 1'b1) begin
                cycles = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [5:0] vec_s;
        repeat (3) @(negedge clk);
        vec_s = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F};
        n_vec++;
        if ({busy, done, pass, first_err_valid, err_count, first_err_vec, first_err_mask, vec_s} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b pass=%b fev=%b err=%0d fvec=%0d fmask=%b vec=%0d, want all 0",
                     busy, done, pass, first_err_valid, err_count, first_err_vec, first_err_mask, vec_s);
        end
        reset = 1'b0;
    endtask

    task automatic test_equivalent;
        int cyc;
        logic [5:0] vec_s;
        mode = 0;
        start_pulse(1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int j = 0; j < 192; j++) begin
            vec_s = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F};
            n_vec++;
            if (vec_s !== 6'(j / 3) || done !== 1'b0) begin
                n_err++;
                $display("FAIL trace_%0d: got vec=%0d done=%b want vec=%0d done=0", j, vec_s, done, j / 3);
            end
            @(negedge clk);
        end
        wait_done(1'b0, cyc);
        n_vec++;
        if (cyc !== 0) begin
            n_err++;
            $display("FAIL equiv_latency: done %0d cycles late (want exactly 192 after start)", cyc);
        end
        n_vec++;
        if ({pass, busy, err_count, first_err_valid} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
            n_err++;
            $display("FAIL equiv_result: got pass=%b busy=%b err=%0d fev=%b want 1 0 0 0",
                     pass, busy, err_count, first_err_valid);
        end
    endtask

    task automatic test_single_error;
        int cyc;
        mode = 1;
        start_pulse(1'b0);
        wait_done(1'b0, cyc);
        n_vec++;
        if (cyc !== 192) begin
            n_err++;
            $display("FAIL single_latency: got %0d want 192", cyc);
        end
        n_vec++;
        if ({err_count, first_err_valid, first_err_vec, first_err_mask, pass} !== {7'd1, 1'b1, 6'd37, 3'b001, 1'b0}) begin
            n_err++;
            $display("FAIL single_result: got err=%0d fev=%b fvec=%0d fmask=%b pass=%b want 1 1 37 001 0",
                     err_count, first_err_valid, first_err_vec, first_err_mask, pass);
        end
    endtask

    task automatic test_many_errors;
        int cyc;
        mode = 2;
        start_pulse(1'b0);
        wait_done(1'b0, cyc);
        n_vec++;
        if ({err_count, first_err_valid, first_err_vec, first_err_mask, pass} !== {7'd32, 1'b1, 6'd2, 3'b010, 1'b0} || cyc !== 192) begin
            n_err++;
            $display("FAIL many_result: got err=%0d fev=%b fvec=%0d fmask=%b pass=%b cyc=%0d want 32 1 2 010 0 192",
                     err_count, first_err_valid, first_err_vec, first_err_mask, pass, cyc);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int cyc;
        logic [5:0] vec_s;
        mode = 2;
        start_pulse(1'b0);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        #1;
        vec_s = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F};
        n_vec++;
        if ({busy, done, pass, first_err_valid, err_count, first_err_vec, first_err_mask, vec_s} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b err=%0d fev=%b fvec=%0d vec=%0d want all 0",
                     busy, done, err_count, first_err_valid, first_err_vec, vec_s);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vec_s = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F};
        n_vec++;
        if ({busy, done, vec_s} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b vec=%0d want 0 0 0", busy, done, vec_s);
        end
        start_pulse(1'b0);
        wait_done(1'b0, cyc);
        n_vec++;
        if (cyc !== 192 || err_count !== 7'd32) begin
            n_err++;
            $display("FAIL reset_resweep: got cyc=%0d err=%0d want 192 32", cyc, err_count);
        end
    endtask

    task automatic test_start_ignored;
        int k;
        mode = 1;
        start_pulse(1'b0);
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            start = (k == 20 || k == 100) ? 1'b1 : 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_vec++;
        if (k !== 192 || err_count !== 7'd1 || first_err_vec !== 6'd37) begin
            n_err++;
            $display("FAIL start_busy: got cyc=%0d err=%0d fvec=%0d want 192 1 37", k, err_count, first_err_vec);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || err_count !== 7'd1) begin
            n_err++;
            $display("FAIL done_hold: got done=%b err=%0d want 1 1", done, err_count);
        end
        start_pulse(1'b0);
        n_vec++;
        if ({done, busy, err_count, first_err_valid, first_err_vec, first_err_mask} !== {1'b0, 1'b1, 7'd0, 1'b0, 6'd0, 3'b000}) begin
            n_err++;
            $display("FAIL restart_clear: got done=%b busy=%b err=%0d fev=%b fvec=%0d fmask=%b want 0 1 0 0 0 000",
                     done, busy, err_count, first_err_valid, first_err_vec, first_err_mask);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_settle;
        int cyc;
        mode = 1;
        start_pulse(1'b1);
        wait_done(1'b1, cyc);
        n_vec++;
        if (cyc !== 64) begin
            n_err++;
            $display("FAIL zero_latency: got %0d want 64", cyc);
        end
        n_vec++;
        if ({err_count0, first_err_valid0, first_err_vec0, first_err_mask0, pass0} !== {7'd1, 1'b1, 6'd37, 3'b001, 1'b0}) begin
            n_err++;
            $display("FAIL zero_result: got err=%0d fev=%b fvec=%0d fmask=%b pass=%b want 1 1 37 001 0",
                     err_count0, first_err_valid0, first_err_vec0, first_err_mask0, pass0);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        mode   = 0;
        test_reset();
        test_equivalent();
        test_single_error();
        test_many_errors();
        test_reset_mid_sweep();
        test_start_ignored();
        test_zero_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
